// File: rtl/sif_wa_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sif_wa_buffer_pkg
// Brief    : Shared widths and entry type for the SIF WA write buffer.
// Revision : 1.0 - initial release
// ============================================================================
package sif_wa_buffer_pkg;

   localparam int SIF_ADDR_W = 16;
   localparam int SIF_DATA_W = 16;

   typedef struct packed {
      logic [SIF_ADDR_W-1:0] addr;
      logic [SIF_DATA_W-1:0] data;
   } wa_entry_t;

endpackage
`default_nettype wire

// File: rtl/sif_wa_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sif_wa_buffer_sync_fifo
// Brief    : Single-clock FIFO; occupancy tracked in a level register.
// Revision : 1.0 - initial release
// ============================================================================
module sif_wa_buffer_sync_fifo
   import sif_wa_buffer_pkg::*;
#(
   parameter int WIDTH = SIF_ADDR_W + SIF_DATA_W,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_LVL_W = c_PTR_W + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         r_level <= r_level + c_LVL_W'(push) - c_LVL_W'(pop);
      end
   end

   // Storage is not reset; only slots behind a nonzero level are ever read out.
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= wr_data;
   end

   assign rd_data = r_mem[r_rd_ptr];
   assign level   = r_level;
   assign full    = (r_level == c_LVL_W'(DEPTH));
   assign empty   = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/sif_wa_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sif_wa_buffer
// Brief    : Buffers SIF WA writes and replays them over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module sif_wa_buffer
   import sif_wa_buffer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = SIF_ADDR_W,
   parameter int DATA_W = SIF_DATA_W,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wa_wr_s,
   input  logic [ADDR_W-1:0]        wa_addr,
   input  logic [DATA_W-1:0]        wa_data_wr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_cnt,
   input  logic                     ovf_clr
);

   localparam int c_ENT_W = ADDR_W + DATA_W;

   logic [c_ENT_W-1:0] w_head;
   logic               w_push;
   logic               w_pop;
   logic               w_drop;
   logic               r_overflow;
   logic [CNT_W-1:0]   r_drop_cnt;

   // A full buffer still accepts a write in the cycle its head is popped.
   assign w_pop  = out_valid & out_ready;
   assign w_push = !rst & wa_wr_s & (!full | w_pop);
   assign w_drop = wa_wr_s & full & !w_pop;

   sif_wa_buffer_sync_fifo #(
      .WIDTH (c_ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push),
      .wr_data ({wa_addr, wa_data_wr}),
      .pop     (w_pop),
      .rd_data (w_head),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         // A drop outranks a coincident clear: the new drop is counted from 1.
         r_overflow <= 1'b1;
         if (ovf_clr)
            r_drop_cnt <= CNT_W'(1);
         else if (r_drop_cnt != '1)
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

   assign out_valid = !empty;
   assign out_addr  = out_valid ? w_head[c_ENT_W-1:DATA_W] : '0;
   assign out_data  = out_valid ? w_head[DATA_W-1:0]       : '0;
   assign overflow  = r_overflow;
   assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sif_wa_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sif_wa_buffer
// Brief    : Self-checking bench: queue-based reference plus directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sif_wa_buffer;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 8;
   localparam int c_CMAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wa_wr_s = 1'b0;
   logic [ADDR_W-1:0] wa_addr = '0;
   logic [DATA_W-1:0] wa_data_wr = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic [$clog2(DEPTH):0] level;
   logic              full;
   logic              empty;
   logic              overflow;
   logic [CNT_W-1:0]  drop_cnt;
   logic              ovf_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   sif_wa_buffer #(
      .DEPTH (DEPTH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
   ) dut (
      .clk (clk), .rst (rst), .wa_wr_s (wa_wr_s), .wa_addr (wa_addr),
      .wa_data_wr (wa_data_wr), .out_valid (out_valid), .out_ready (out_ready),
      .out_addr (out_addr), .out_data (out_data), .level (level), .full (full),
      .empty (empty), .overflow (overflow), .drop_cnt (drop_cnt), .ovf_clr (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: ordered queue of {addr,data}, sticky flag and saturating count.
   logic [ADDR_W+DATA_W-1:0] mq[$];
   bit m_ovf = 1'b0;
   int m_cnt = 0;

   always @(posedge clk) begin
      bit p, f, pu, dr;
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
         m_cnt = 0;
      end else begin
         p  = (mq.size() > 0) && out_ready;
         f  = (mq.size() == DEPTH);
         pu = wa_wr_s && (!f || p);
         dr = wa_wr_s && f && !p;
         if (p)  void'(mq.pop_front());
         if (pu) mq.push_back({wa_addr, wa_data_wr});
         if (dr) begin
            m_ovf = 1'b1;
            m_cnt = ovf_clr ? 1 : ((m_cnt == c_CMAX) ? c_CMAX : m_cnt + 1);
         end else if (ovf_clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [ADDR_W+DATA_W-1:0] h;
         h = (mq.size() > 0) ? mq[0] : '0;
         chk("m_valid", 32'(out_valid), 32'(mq.size() > 0));
         chk("m_addr",  32'(out_addr),  32'(h[ADDR_W+DATA_W-1:DATA_W]));
         chk("m_data",  32'(out_data),  32'(h[DATA_W-1:0]));
         chk("m_level", 32'(level),     32'(mq.size()));
         chk("m_full",  32'(full),      32'(mq.size() == DEPTH));
         chk("m_empty", 32'(empty),     32'(mq.size() == 0));
         chk("m_ovf",   32'(overflow),  32'(m_ovf));
         chk("m_cnt",   32'(drop_cnt),  32'(m_cnt));
      end
   end

   // Drive one cycle's inputs just after a falling edge, return after the next one.
   task automatic cyc(input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input bit rdy, input bit clr = 1'b0, input bit r = 1'b0);
      #1;
      wa_wr_s = wr; wa_addr = a; wa_data_wr = d;
      out_ready = rdy; ovf_clr = clr; rst = r;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk_en = 1'b1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_level", 32'(level), 0);
      chk("rst_addr",  32'(out_addr), 0);

      // In-order pass-through, one cycle behind each push.
      cyc(1, 16'h0010, 16'hAAAA, 1);
      chk("t1_a0", {out_addr, out_data}, 32'h0010AAAA);
      cyc(1, 16'h0012, 16'hBBBB, 1);
      chk("t1_a1", {out_addr, out_data}, 32'h0012BBBB);
      chk("t1_lvl", 32'(level <= 1), 1);
      cyc(1, 16'h0014, 16'hCCCC, 1);
      chk("t1_a2", {out_addr, out_data}, 32'h0014CCCC);
      chk("t1_lvl", 32'(level <= 1), 1);
      cyc(0, 0, 0, 1);
      chk("t1_empty", 32'(empty), 1);

      // Fill while stalled, then one write too many.
      for (int i = 0; i < 8; i++) cyc(1, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 0);
      chk("t2_full", 32'(full), 1);
      cyc(1, 16'h00FF, 16'hDEAD, 0);
      chk("t2_ovf", 32'(overflow), 1);
      chk("t2_cnt", 32'(drop_cnt), 1);
      chk("t2_lvl", 32'(level), 8);
      for (int i = 0; i < 8; i++) begin
         chk("t2_head", {out_addr, out_data}, {16'h0100 + 16'(i), 16'h1000 + 16'(i)});
         cyc(0, 0, 0, 1);
      end
      chk("t2_empty", 32'(empty), 1);

      // Write and pop together on a full buffer.
      for (int i = 0; i < 8; i++) cyc(1, 16'h0300 + 16'(i), 16'h3000 + 16'(i), 0);
      cyc(1, 16'h0200, 16'h2222, 1);
      chk("t3_lvl", 32'(level), 8);
      chk("t3_cnt", 32'(drop_cnt), 1);
      for (int i = 1; i < 8; i++) begin
         chk("t3_head", {out_addr, out_data}, {16'h0300 + 16'(i), 16'h3000 + 16'(i)});
         cyc(0, 0, 0, 1);
      end
      chk("t3_last", {out_addr, out_data}, 32'h02002222);
      cyc(0, 0, 0, 1);

      // Saturation, then clear coincident with a drop, then a plain clear.
      for (int i = 0; i < 8; i++) cyc(1, 16'h0400 + 16'(i), 16'h4000 + 16'(i), 0);
      for (int i = 0; i < 300; i++) cyc(1, 16'h0500, 16'(i), 0);
      chk("t4_sat", 32'(drop_cnt), 255);
      cyc(1, 16'h0501, 16'h5555, 0, 1);
      chk("t4_clrdrop_ovf", 32'(overflow), 1);
      chk("t4_clrdrop_cnt", 32'(drop_cnt), 1);
      cyc(0, 0, 0, 0, 1);
      chk("t4_clr_ovf", 32'(overflow), 0);
      chk("t4_clr_cnt", 32'(drop_cnt), 0);

      // Reset with entries held and a write strobe present.
      cyc(1, 16'h0600, 16'h6666, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      chk("t5_lvl5", 32'(level), 5);
      cyc(1, 16'h0700, 16'h7777, 1, 0, 1);
      chk("t5_lvl", 32'(level), 0);
      chk("t5_valid", 32'(out_valid), 0);
      chk("t5_cnt", 32'(drop_cnt), 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 1);
         chk("t5_quiet", 32'(out_valid), 0);
      end

      // Random traffic against the reference.
      for (int i = 0; i < 10000; i++)
         cyc(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 1);
      chk("t6_empty", 32'(empty), 1);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
